// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Purpose: shares one external combinational ALU between two requesters.
// Port 0 is the core datapath and port 1 is the auxiliary/debug unit. A
// request is accepted over a valid/ready handshake in IDLE. The operands are
// latched and presented to the ALU for one EXEC cycle. The ALU outputs are
// then captured and returned over a per-port valid/ready response handshake
// in RESP.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration (favoured-port pointer register)
//   undefined -> fixed priority, port 0 wins ties (no pointer register)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for port N
//   reqN_a, reqN_b, reqN_op     operands and 3-bit ALU op code for port N
//   respN_valid / respN_ready   response handshake for port N
//   resp_result, resp_zero      registered ALU result / zero flag (shared)
//   alu_a, alu_b, alu_op        drive the external ALU (latched operands)
//   alu_result, alu_zero        external ALU outputs
//   busy                        high whenever the FSM is not in IDLE
module alu_share_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [W-1:0] resp_result,
    output logic         resp_zero,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic         gnt_q, gnt_d;
    logic [W-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         grant0, grant1;
    logic         accept;
    logic         respDone;

`ifdef ALU_ARB_RR_EN
    logic         rr_q, rr_d;

    // Round-robin grant: the pointer names the port that wins a tie, and a
    // lone requester always wins regardless of the pointer.
    always_comb begin
        if (!rr_q) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end else begin
            grant1 = req1_valid;
            grant0 = req0_valid && !req1_valid;
        end
    end
`else
    // Fixed priority grant: port 1 only gets the ALU when port 0 is silent.
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    // Readys are only offered in IDLE; this is the sole input-to-output
    // combinational path in the block.
    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign respDone   = gnt_q ? resp1_ready : resp0_ready;

    // Next-state logic. The operand registers only change on an accepted
    // request, so the ALU inputs hold steady outside EXEC instead of
    // glitching back to zero.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = req1_ready ? req1_a  : req0_a;
                    b_d     = req1_ready ? req1_b  : req0_b;
                    op_d    = req1_ready ? req1_op : req0_op;
                    gnt_d   = req1_ready;
                    state_d = EXEC;
`ifdef ALU_ARB_RR_EN
                    rr_d    = !req1_ready;
`endif
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (respDone) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register block; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            gnt_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp0_valid = (state_q == RESP) && !gnt_q;
    assign resp1_valid = (state_q == RESP) && gnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter. It provides a behavioural model of the
// external ALU (ADD=0, SUB=1, MUL=2, AND=3, OR=4, SLL=5, others yield 0).
// Directed scenarios come first, then a randomized run that is checked
// against a phase/owner/favoured-port model of the sharing rules.
module tb_alu_share_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         alu_zero;
    logic         busy;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    // Behavioural ALU from the op-code table.
    function automatic logic [W-1:0] aluRef(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a << b[4:0];
            default: return '0;
        endcase
    endfunction

    assign alu_result = aluRef(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    alu_share_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = 3'd0;
        req1_a = '0; req1_b = '0; req1_op = 3'd0;
    endtask

    task automatic doReset();
        reset = 1; idleInputs(); tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idleInputs(); tick(); tick();
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
        checkCount++; if ({resp1_valid, resp0_valid} !== 2'b00) $display("[TB] FAIL reset_resp_valid: got %b want 00", {resp1_valid, resp0_valid}); else passCount++;
        checkCount++; if ({resp_zero, resp_result} !== '0) $display("[TB] FAIL reset_result: got %b/%h want 0/0", resp_zero, resp_result); else passCount++;
        checkCount++; if ({alu_op, alu_a, alu_b} !== '0) $display("[TB] FAIL reset_alu_in: got %h/%h/%h want 0", alu_op, alu_a, alu_b); else passCount++;
        reset = 0; tick();
        req1_valid = 1; #1;
        checkCount++; if ({req1_ready, req0_ready} !== 2'b10) $display("[TB] FAIL lone_req1_ready: got %b want 10", {req1_ready, req0_ready}); else passCount++;
        req1_valid = 0; tick();
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL withdraw_no_accept: busy got %b want 0", busy); else passCount++;
    endtask

    task automatic test_single_op();
        req0_valid = 1; req0_op = 3'd0; req0_a = 5; req0_b = 7; #1;
        checkCount++; if ({req1_ready, req0_ready} !== 2'b01) $display("[TB] FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); else passCount++;
        tick(); req0_valid = 0; #1;
        checkCount++; if ({busy, resp0_valid, alu_a, alu_b} !== {1'b1, 1'b0, 32'd5, 32'd7}) $display("[TB] FAIL single_exec: busy %b rv %b a %0d b %0d want 1 0 5 7", busy, resp0_valid, alu_a, alu_b); else passCount++;
        tick(); resp0_ready = 1; #1;
        checkCount++; if ({resp0_valid, resp1_valid, resp_zero, resp_result} !== {1'b1, 1'b0, 1'b0, 32'd12}) $display("[TB] FAIL single_resp: got v%b%b z%b r%0d want v10 z0 r12", resp0_valid, resp1_valid, resp_zero, resp_result); else passCount++;
        tick(); resp0_ready = 0; #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL single_done_busy: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_zero_flag();
        bit saw0;
        saw0 = 0;
        req1_valid = 1; req1_op = 3'd1; req1_a = 32'h1234; req1_b = 32'h1234; resp1_ready = 1; #1;
        checkCount++; if (req1_ready !== 1'b1) $display("[TB] FAIL zero_ready: got %b want 1", req1_ready); else passCount++;
        saw0 |= resp0_valid;
        tick(); req1_valid = 0; #1; saw0 |= resp0_valid;
        tick(); #1; saw0 |= resp0_valid;
        checkCount++; if ({resp1_valid, resp_zero, resp_result} !== {1'b1, 1'b1, 32'd0}) $display("[TB] FAIL zero_resp: got v%b z%b r%h want v1 z1 r0", resp1_valid, resp_zero, resp_result); else passCount++;
        tick(); resp1_ready = 0; #1; saw0 |= resp0_valid;
        checkCount++; if ({saw0, busy} !== 2'b00) $display("[TB] FAIL zero_resp0_quiet: saw0 %b busy %b want 0 0", saw0, busy); else passCount++;
    endtask

    task automatic test_contention();
        int rem[2];
        int fav, expG, got, grants;
        logic hs0, hs1;
        doReset();
        fav = 0; rem[0] = 4; rem[1] = 4; grants = 0; got = 0;
        req0_valid = 1; req0_op = 3'd2; req0_a = 3; req0_b = 4;
        req1_valid = 1; req1_op = 3'd5; req1_a = 1; req1_b = 31;
        resp0_ready = 1; resp1_ready = 1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0 || hs1) begin
                if (rem[0] > 0 && rem[1] > 0) expG = RR ? fav : 0;
                else expG = (rem[0] > 0) ? 0 : 1;
                got = hs1 ? 1 : 0;
                checkCount++; if ((hs0 && hs1) || got != expG) $display("[TB] FAIL contention_grant%0d: got %0d (both=%b) want %0d", grants, got, hs0 && hs1, expG); else passCount++;
            end
            if (resp0_valid) begin
                checkCount++; if (resp_result !== 32'd12) $display("[TB] FAIL contention_res0: got %h want 0000000c", resp_result); else passCount++;
            end
            if (resp1_valid) begin
                checkCount++; if (resp_result !== 32'h8000_0000) $display("[TB] FAIL contention_res1: got %h want 80000000", resp_result); else passCount++;
            end
            tick();
            if (hs0 || hs1) begin
                rem[got]--; fav = 1 - got; grants++;
                if (rem[got] == 0) begin
                    if (got == 0) req0_valid = 0; else req1_valid = 0;
                end
            end
            if (grants == 8 && !busy) break;
        end
        checkCount++; if (grants != 8 || busy !== 1'b0) $display("[TB] FAIL contention_done: grants %0d busy %b want 8 0", grants, busy); else passCount++;
        idleInputs();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        tick();
        req0_valid = 1; req0_op = 3'd4; req0_a = 32'hF0; req0_b = 32'h0F; #1;
        checkCount++; if (req0_ready !== 1'b1) $display("[TB] FAIL bp_accept: got %b want 1", req0_ready); else passCount++;
        tick(); req0_valid = 0; tick();
        req1_valid = 1; req1_op = 3'd0; resp0_ready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ({resp0_valid, resp1_valid, resp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 32'hFF, 1'b0, 1'b0}) bad++;
            tick();
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL bp_stable: got %0d bad cycles want 0 (last rv %b r %h)", bad, resp0_valid, resp_result); else passCount++;
        resp0_ready = 1; req1_valid = 0; tick(); resp0_ready = 0; #1;
        checkCount++; if ({busy, resp0_valid, resp1_valid} !== 3'b000) $display("[TB] FAIL bp_release_idle: got %b want 000", {busy, resp0_valid, resp1_valid}); else passCount++;
    endtask

    task automatic test_reset_mid_op();
        bit sawResp;
        sawResp = 0;
        req0_valid = 1; req0_op = 3'd3; req0_a = 32'hFF; req0_b = 32'h0F; #1;
        tick(); req0_valid = 0;
        reset = 1; resp0_ready = 1; #1;
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL midrst_in_exec: busy got %b want 1", busy); else passCount++;
        tick(); reset = 0; resp0_ready = 0; #1;
        checkCount++; if ({busy, resp0_valid, resp1_valid, resp_zero, resp_result, alu_a, alu_b, alu_op} !== '0) $display("[TB] FAIL midrst_values: busy %b rv %b%b z %b r %h a %h op %0d want all 0", busy, resp0_valid, resp1_valid, resp_zero, resp_result, alu_a, alu_op); else passCount++;
        for (int i = 0; i < 3; i++) begin
            sawResp |= resp0_valid | resp1_valid | busy;
            tick();
        end
        checkCount++; if (sawResp !== 1'b0) $display("[TB] FAIL midrst_no_resp: got %b want 0", sawResp); else passCount++;
        req1_valid = 1; req1_op = 3'd0; req1_a = 1; req1_b = 2; #1;
        checkCount++; if (req1_ready !== 1'b1) $display("[TB] FAIL midrst_next_ready: got %b want 1", req1_ready); else passCount++;
        tick(); req1_valid = 0; tick(); resp1_ready = 1; #1;
        checkCount++; if ({resp1_valid, resp_result} !== {1'b1, 32'd3}) $display("[TB] FAIL midrst_next_resp: got v%b r%0d want v1 r3", resp1_valid, resp_result); else passCount++;
        tick(); resp1_ready = 0;
    endtask

    task automatic test_unsupported_op();
        req0_valid = 1; req0_op = 3'd7; req0_a = 9; req0_b = 9; resp0_ready = 1; #1;
        checkCount++; if (req0_ready !== 1'b1) $display("[TB] FAIL op7_ready: got %b want 1", req0_ready); else passCount++;
        tick(); req0_valid = 0; #1;
        checkCount++; if ({busy, alu_op} !== {1'b1, 3'd7}) $display("[TB] FAIL op7_exec: busy %b op %0d want 1 7", busy, alu_op); else passCount++;
        tick(); #1;
        checkCount++; if ({resp0_valid, resp_zero, resp_result} !== {1'b1, 1'b1, 32'd0}) $display("[TB] FAIL op7_resp: got v%b z%b r%h want v1 z1 r0", resp0_valid, resp_zero, resp_result); else passCount++;
        tick(); resp0_ready = 0; #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL op7_done: busy got %b want 0", busy); else passCount++;
    endtask

    // Random traffic against a model that only knows the sharing rules: a
    // phase (idle/exec/resp), the current owner, the expected result and
    // which port is favoured on a tie.
    task automatic test_random();
        int phase, owner, fav, done, expG;
        logic [W-1:0] expRes;
        logic [1:0] expReady, expValid;
        doReset();
        phase = 0; owner = 0; fav = 0; done = 0; expRes = '0;
        for (int cyc = 0; cyc < 3000 && done < 40; cyc++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_op = 3'($urandom_range(0, 7));
                req0_a = $urandom; req0_b = $urandom;
                if ($urandom_range(0, 3) == 0) req0_b = req0_a;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_op = 3'($urandom_range(0, 7));
                req1_a = $urandom; req1_b = $urandom;
                if ($urandom_range(0, 3) == 0) req1_b = req1_a;
            end
            resp0_ready = 1'($urandom_range(0, 1));
            resp1_ready = 1'($urandom_range(0, 1));
            #1;
            if (phase != 0) expG = -1;
            else if (req0_valid && req1_valid) expG = RR ? fav : 0;
            else if (req0_valid) expG = 0;
            else if (req1_valid) expG = 1;
            else expG = -1;
            expReady = {expG == 1, expG == 0};
            expValid = {phase == 2 && owner == 1, phase == 2 && owner == 0};
            checkCount++; if ({req1_ready, req0_ready} !== expReady) $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, {req1_ready, req0_ready}, expReady); else passCount++;
            checkCount++; if ({resp1_valid, resp0_valid} !== expValid || busy !== (phase != 0)) $display("[TB] FAIL rand_valid@%0d: got %b busy %b want %b busy %b", cyc, {resp1_valid, resp0_valid}, busy, expValid, phase != 0); else passCount++;
            if (phase == 2) begin
                checkCount++; if ({resp_zero, resp_result} !== {expRes == '0, expRes}) $display("[TB] FAIL rand_result@%0d: got z%b r%h want z%b r%h", cyc, resp_zero, resp_result, expRes == '0, expRes); else passCount++;
            end
            tick();
            case (phase)
                0: if (expG >= 0) begin
                       owner = expG; fav = 1 - expG; phase = 1;
                       if (expG == 0) begin expRes = aluRef(req0_op, req0_a, req0_b); req0_valid = 0; end
                       else begin expRes = aluRef(req1_op, req1_a, req1_b); req1_valid = 0; end
                   end
                1: phase = 2;
                default: if ((owner == 0 && resp0_ready) || (owner == 1 && resp1_ready)) begin
                       phase = 0; done++;
                   end
            endcase
        end
        checkCount++; if (done != 40) $display("[TB] FAIL rand_done: got %0d ops want 40", done); else passCount++;
        idleInputs();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1;
        idleInputs();
        test_reset();
        test_single_op();
        test_zero_flag();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_unsupported_op();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
